// File: rtl/row_deserializer_if.sv
// Valid/ready bus for row_deserializer: LANES-bit beat input side and DATA_SIZE-bit word output side.
// The slave modport is the deserializer's view; master is the producer/consumer view.
interface row_deserializer_if #(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned LANES     = 1
);
  logic [LANES-1:0]     in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/row_deserializer.sv
// Multi-lane valid/ready deserializer: packs DATA_SIZE/LANES beats into one word, first beat on top.
// Define DESER_DOUBLE_BUFFER_EN to add an output register so assembly overlaps the downstream wait.
module row_deserializer #(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned LANES     = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  row_deserializer_if.slave io_bus
);
  localparam int unsigned      BEATS    = DATA_SIZE / LANES;
  localparam int unsigned      CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  if ((LANES == 0) || (DATA_SIZE % LANES != 0)) begin : g_bad_cfg
    $error("row_deserializer: LANES must divide DATA_SIZE exactly");
  end

  typedef enum logic {
    StFill = 1'b0,
    StHold = 1'b1
  } state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_next;
  logic [DATA_SIZE-1:0] r_shift;
  logic [DATA_SIZE-1:0] w_shift_next;
  logic [DATA_SIZE-1:0] w_shifted;
  logic                 w_last;

  // Incoming beat enters at the bottom; a full-width beat simply replaces the register.
  if (LANES == DATA_SIZE) begin : g_direct
    assign w_shifted = io_bus.in_data;
  end else begin : g_shift
    assign w_shifted = {r_shift[DATA_SIZE-LANES-1:0], io_bus.in_data};
  end

  assign w_last          = (r_count == LAST_CNT);
  assign io_bus.in_ready = (r_state == StFill);

`ifdef DESER_DOUBLE_BUFFER_EN
  logic [DATA_SIZE-1:0] r_out_data;
  logic [DATA_SIZE-1:0] w_out_data_next;
  logic                 r_out_valid;
  logic                 w_out_valid_next;
  logic                 w_out_free;

  // The output register can take a new word if empty or being consumed this cycle.
  assign w_out_free = !r_out_valid || io_bus.out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_shift_next     = r_shift;
    w_out_data_next  = r_out_data;
    w_out_valid_next = r_out_valid && !io_bus.out_ready;
    unique case (r_state)
      StFill: begin
        if (i_clr) begin
          w_count_next = '0;
          w_shift_next = '0;
        end else if (io_bus.in_valid) begin
          w_shift_next = w_shifted;
          if (w_last) begin
            w_count_next = '0;
            if (w_out_free) begin
              w_out_data_next  = w_shifted;
              w_out_valid_next = 1'b1;
            end else begin
              w_state_next = StHold;
            end
          end else begin
            w_count_next = r_count + CNT_W'(1);
          end
        end
      end
      StHold: begin
        // Only reached with a word presented, so the waiting word is the one CLR may drop.
        if (i_clr) begin
          w_shift_next = '0;
          w_state_next = StFill;
        end else if (io_bus.out_ready) begin
          w_out_data_next  = r_shift;
          w_out_valid_next = 1'b1;
          w_state_next     = StFill;
        end
      end
      default: w_state_next = StFill;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
    end
  end

  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_valid = r_out_valid;
`else
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_shift_next = r_shift;
    unique case (r_state)
      StFill: begin
        if (i_clr) begin
          w_count_next = '0;
          w_shift_next = '0;
        end else if (io_bus.in_valid) begin
          w_shift_next = w_shifted;
          if (w_last) begin
            w_count_next = '0;
            w_state_next = StHold;
          end else begin
            w_count_next = r_count + CNT_W'(1);
          end
        end
      end
      StHold: begin
        // The held word is already presented, so CLR cannot touch it.
        if (io_bus.out_ready) begin
          w_state_next = StFill;
        end
      end
      default: w_state_next = StFill;
    endcase
  end

  assign io_bus.out_data  = r_shift;
  assign io_bus.out_valid = (r_state == StHold);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StFill;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_shift <= '0;
    end else begin
      r_count <= w_count_next;
      r_shift <= w_shift_next;
    end
  end
endmodule

// File: tb/tb_row_deserializer.sv
// Directed and randomized bench for row_deserializer across four lane/width configurations.
module tb_row_deserializer;
`ifdef DESER_DOUBLE_BUFFER_EN
  localparam logic DBL = 1'b1;
`else
  localparam logic DBL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic clr_a, clr_b, clr_c, clr_d;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  row_deserializer_if #(.DATA_SIZE(8),  .LANES(2)) bus_a ();
  row_deserializer_if #(.DATA_SIZE(64), .LANES(1)) bus_b ();
  row_deserializer_if #(.DATA_SIZE(8),  .LANES(8)) bus_c ();
  row_deserializer_if #(.DATA_SIZE(16), .LANES(4)) bus_d ();

  row_deserializer #(.DATA_SIZE(8), .LANES(2)) u_a (
    .i_clk(clk), .i_rst(rst), .i_clr(clr_a), .io_bus(bus_a));
  row_deserializer #(.DATA_SIZE(64), .LANES(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_clr(clr_b), .io_bus(bus_b));
  row_deserializer #(.DATA_SIZE(8), .LANES(8)) u_c (
    .i_clk(clk), .i_rst(rst), .i_clr(clr_c), .io_bus(bus_c));
  row_deserializer #(.DATA_SIZE(16), .LANES(4)) u_d (
    .i_clk(clk), .i_rst(rst), .i_clr(clr_d), .io_bus(bus_d));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  pat [4];
    logic [7:0]  got_a [$];
    logic [15:0] exp_q [$];
    logic [15:0] acc;
    logic [15:0] prev_data;
    logic [15:0] exp_w;
    logic [3:0]  beat;
    logic        iv, ordy, rdy0, vld0, prev_stall, stable_ok, hold_ok, data_ok;
    int          nb, fed, got, extra, cyc, nvalid;

    pat = '{2'b10, 2'b01, 2'b11, 2'b00};
    rst = 1'b1;
    {clr_a, clr_b, clr_c, clr_d} = '0;
    bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.out_ready = 0;
    bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.out_ready = 0;
    bus_c.in_valid = 0; bus_c.in_data = '0; bus_c.out_ready = 0;
    bus_d.in_valid = 0; bus_d.in_data = '0; bus_d.out_ready = 0;

    // Reset values while reset is held.
    #2;
    check("rst a in_ready", bus_a.in_ready, 1);
    check("rst a out_valid", bus_a.out_valid, 0);
    check("rst a out_data", bus_a.out_data, 0);
    check("rst b in_ready", bus_b.in_ready, 1);
    check("rst b out_data", bus_b.out_data, 0);
    check("rst d out_valid", bus_d.out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Test 1: four beats with downstream ready.
    bus_a.out_ready = 1; bus_a.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_data = pat[i];
      if (i == 3) check("t1 valid early", bus_a.out_valid, 0);
      tick();
    end
    bus_a.in_valid = 0;
    check("t1 out_valid", bus_a.out_valid, 1);
    check("t1 out_data", bus_a.out_data, 8'h9C);
    check("t1 in_ready", bus_a.in_ready, DBL);
    tick();
    check("t1 drained", bus_a.out_valid, 0);

    // Test 2: downstream stalls for 10 cycles with input always offered.
    bus_a.out_ready = 0; bus_a.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_data = pat[i];
      tick();
    end
    check("t2 in_ready after word", bus_a.in_ready, DBL);
    bus_a.in_data = 2'b11;
    repeat (6) tick();
    check("t2 in_ready stalled", bus_a.in_ready, 0);
    check("t2 out_valid held", bus_a.out_valid, 1);
    check("t2 out_data held", bus_a.out_data, 8'h9C);
    bus_a.in_valid = 0; bus_a.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (bus_a.out_valid) got_a.push_back(bus_a.out_data);
      tick();
    end
    bus_a.out_ready = 0;
    nb = got_a.size();
    check("t2 word count", 64'(nb), DBL ? 64'd2 : 64'd1);
    check("t2 first word", got_a[0], 8'h9C);
    check("t2 last word", got_a[nb-1], DBL ? 8'hFF : 8'h9C);

    // Test 3: CLR after 30 beats drops the partial word and the coincident beat.
    bus_b.out_ready = 1; bus_b.in_valid = 1;
    for (int i = 0; i < 30; i++) begin
      bus_b.in_data = 1'($urandom);
      tick();
    end
    clr_b = 1; bus_b.in_data = 1'b1;
    check("t3 in_ready at clr", bus_b.in_ready, 1);
    tick();
    clr_b = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 63) check("t3 valid early", bus_b.out_valid, 0);
      tick();
    end
    bus_b.in_valid = 0;
    check("t3 out_valid", bus_b.out_valid, 1);
    check("t3 out_data", bus_b.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();

    // Test 4: asynchronous reset mid-cycle with a word presented and a partial word.
    bus_a.out_ready = 0; bus_a.in_valid = 1;
    for (int i = 0; i < 7; i++) begin
      bus_a.in_data = (i < 4) ? pat[i] : 2'b11;
      tick();
    end
    bus_a.in_valid = 0;
    check("t4 presented", bus_a.out_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("t4 rst out_valid", bus_a.out_valid, 0);
    check("t4 rst out_data", bus_a.out_data, 0);
    check("t4 rst in_ready", bus_a.in_ready, 1);
    #1 rst = 1'b0;
    tick();
    bus_a.out_ready = 1; bus_a.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_data = pat[(i == 1) ? 2 : (i == 2) ? 1 : i];
      tick();
    end
    bus_a.in_valid = 0;
    check("t4 word valid", bus_a.out_valid, 1);
    check("t4 word data", bus_a.out_data, 8'hB4);
    tick();

    // Test 5: full-width beat every cycle.
    bus_c.in_data = 8'hA5; bus_c.in_valid = 1; bus_c.out_ready = 1;
    tick();
    nvalid = 0; data_ok = 1;
    for (int i = 0; i < 10; i++) begin
      if (bus_c.out_valid) begin
        nvalid++;
        if (bus_c.out_data !== 8'hA5) data_ok = 0;
      end
      tick();
    end
    bus_c.in_valid = 0;
    check("t5 valid cycles", 64'(nvalid), DBL ? 64'd10 : 64'd5);
    check("t5 data", data_ok, 1);
    tick();

    // Test 6: random handshakes, 1000 words against an arithmetic word model.
    acc = '0; nb = 0; fed = 0; got = 0; extra = 0; cyc = 0;
    stable_ok = 1; hold_ok = 1; prev_stall = 0; prev_data = '0;
    while (got < 1000 && cyc < 60000) begin
      if (prev_stall && (bus_d.out_valid !== 1'b1 || bus_d.out_data !== prev_data)) hold_ok = 0;
      rdy0 = bus_d.in_ready;
      vld0 = bus_d.out_valid;
      iv   = (fed < 4000) && ($urandom_range(0, 1) == 1);
      ordy = ($urandom_range(0, 1) == 1);
      beat = 4'($urandom);
      bus_d.in_valid = iv; bus_d.in_data = beat; bus_d.out_ready = ordy;
      #1;
      if (bus_d.in_ready !== rdy0 || bus_d.out_valid !== vld0) stable_ok = 0;
      if (vld0 && ordy) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          exp_w = exp_q.pop_front();
          check("rnd word", bus_d.out_data, exp_w);
        end
        got++;
      end
      if (iv && rdy0) begin
        fed++;
        acc = 16'((acc * 16) + beat);
        nb++;
        if (nb == 4) begin
          exp_q.push_back(acc);
          acc = '0;
          nb  = 0;
        end
      end
      prev_stall = vld0 && !ordy;
      prev_data  = bus_d.out_data;
      tick();
      cyc++;
    end
    bus_d.in_valid = 0; bus_d.out_ready = 0;
    check("rnd words received", 64'(got), 64'd1000);
    check("rnd unexpected words", 64'(extra), 64'd0);
    check("rnd words left", 64'(exp_q.size()), 64'd0);
    check("rnd ready/valid registered", stable_ok, 1);
    check("rnd stall data stable", hold_ok, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/row_deserializer.md
# row_deserializer

Parametrised multi-lane deserializer with valid/ready handshakes on both sides. It assembles one `DATA_SIZE`-bit word per `DATA_SIZE/LANES` accepted beats and presents each complete word until downstream accepts it. It sits between the serial cell-stream input and the row buffer of the life grid, and replaces the fixed single-bit, handshake-free shift register.

## Interface
- `DATA_SIZE`, 64, bits per assembled word.
- `LANES`, 1, bits accepted per beat; must divide `DATA_SIZE` exactly; `BEATS = DATA_SIZE/LANES`.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `CLR`  in  1  synchronous discard of the partial or pending word.
- `DATA_IN`  in  `LANES`  beat payload.
- `IN_VALID`  in  1  beat offered.
- `IN_READY`  out  1  beat accepted when `IN_VALID && IN_READY`.
- `OUT_DATA`  out  `DATA_SIZE`  assembled word.
- `OUT_VALID`  out  1  `OUT_DATA` holds a complete word.
- `OUT_READY`  in  1  word consumed when `OUT_VALID && OUT_READY`.

## Operation
- Shift rule per accepted beat: `shift <= {shift[DATA_SIZE-LANES-1:0], DATA_IN}`. The first beat ends in the top `LANES` bits and the last beat in the bottom `LANES` bits. When `LANES == DATA_SIZE`, the register is loaded directly.
- Beat counter: width `max(1, $clog2(BEATS))`. It counts 0..`BEATS`-1, returns to 0 after the final beat, and never exceeds `BEATS`-1.
- States: FILL (assembling), HOLD (word complete, not yet handed off).
- FILL:
  - `IN_READY = 1`.
  - An accepted beat with count `BEATS`-1 completes the word.
- HOLD:
  - `IN_READY = 0`.
  - Leaves HOLD on handoff (see Configuration).
- `CLR` (FILL or HOLD-not-presented):
  - Count goes to 0, shift goes to 0, state goes to FILL.
  - `CLR` wins over a simultaneous beat; that beat is dropped even though `IN_READY` was 1.
- A word already presented with `OUT_VALID = 1` is never discarded by `CLR`. It is removed only by a handshake or by `RST`.
- `OUT_DATA` holds stable while `OUT_VALID = 1 && OUT_READY = 0`. It is don't-care, though deterministic, while `OUT_VALID = 0`.
- `RST` mid-word: counter, shift register, output register and state clear immediately. The partial word is lost.

## Timing
- Reset values:
  - `OUT_DATA = 0`, `OUT_VALID = 0`.
  - `IN_READY = 1`, decoded from the FILL reset state, including while `RST` is high.
  - Count 0.
- Latency: the final beat accepted at edge k makes `OUT_VALID = 1` after edge k when the output is free.
- `IN_READY` and `OUT_VALID` are decoded from registers only. No combinational path runs from `OUT_READY` or `IN_VALID` to any output.
- Back-to-back handshakes are legal on both sides every cycle that the ready/valid pair allows.

## Configuration
- Macro: `DESER_DOUBLE_BUFFER_EN`.
- Undefined (single buffer):
  - `OUT_DATA` is the shift register itself.
  - HOLD asserts `OUT_VALID`.
  - A handshake returns the block to FILL with count 0.
  - No beat is accepted in the handshake cycle.
  - Throughput is one word per `BEATS+1` cycles at best.
- Defined (double buffer):
  - A separate output register drives `OUT_DATA`/`OUT_VALID`.
  - On word completion, the shift register transfers to the output register at the same edge if the output is empty, or if it is being consumed in that same cycle. Otherwise the block enters HOLD with `OUT_VALID` unaffected.
  - In HOLD, a downstream handshake transfers the waiting word at that edge, and the block returns to FILL.
  - `CLR` in HOLD discards the waiting word; the presented word remains.
  - Sustains one word per `BEATS` cycles with `OUT_READY` held high.

## Test plan
- `DATA_SIZE=8`, `LANES=2`, beats 2'b10, 2'b01, 2'b11, 2'b00 on consecutive cycles, `OUT_READY=1` -> `OUT_DATA=8'h9C`, `OUT_VALID` high one cycle after the 4th beat.
- Same config, `OUT_READY=0` for 10 cycles while `IN_VALID` stays high:
  - Undefined: `IN_READY` low after the 4th beat.
  - Defined: a second word (all 2'b11) is absorbed, then `IN_READY` drops; `OUT_DATA` stays 8'h9C.
  - Release `OUT_READY` -> 8'h9C, then 8'hFF, in order.
- `DATA_SIZE=64`, `LANES=1`, 30 beats then `CLR` with `IN_VALID=1` -> count 0, beat dropped; the next 64 beats of 1 give `OUT_DATA=64'hFFFF_FFFF_FFFF_FFFF`.
- `RST` pulsed asynchronously mid-cycle after beat 3 of 4, with a word presented -> `OUT_VALID=0` and `OUT_DATA=0` immediately, `IN_READY=1`; the next full word assembles correctly.
- `LANES=DATA_SIZE=8`, `DATA_IN=8'hA5` every cycle, `OUT_READY=1` -> defined: 8'hA5 every cycle; undefined: every other cycle.
- Random `IN_VALID`/`OUT_READY` at 50 %, 1000 words, `LANES=4` -> a scoreboard matches every word in order, with no loss or duplication.
